imm_decode_pipe: RTL and testbench

Registered, flow-controlled immediate decoder for the RV32I/RV64I core's decode stage. It takes a raw instruction word plus a sideband tag over a valid/ready handshake, classifies the format from the opcode itself, and returns the sign-extended immediate, format code and illegal flag one cycle later. A two-entry skid buffer lets fetch and execute stall each other without bubbles. It replaces the flag-driven combinational immediate generator; callers no longer supply format flags.

---
 rtl/imm_decode_pipe_pkg.sv | 34 +++
 rtl/imm_decode_pipe_extract.sv | 62 ++++++
 rtl/imm_decode_pipe.sv | 121 ++++++++++++
 tb/tb_imm_decode_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_decode_pipe_pkg.sv
// Shared types and opcode constants for the registered immediate decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  // Occupancy of the head/skid pair.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_decode_pipe_extract.sv
// Combinational opcode classifier and sign-extended immediate builder.
// IMM_CSR_ZIMM_EN selects the zero-extended CSR immediate (format Z).
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_ILL;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM: begin
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(inst_i[31:20]));
      end
      OPC_SYSTEM: begin
`ifdef IMM_CSR_ZIMM_EN
        if (inst_i[14]) begin
          fmt_o = FMT_Z;
          imm_o = XLEN'(inst_i[19:15]);
        end else begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(inst_i[31:20]));
        end
`else
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(inst_i[31:20]));
`endif
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      end
      OPC_OP: begin
        fmt_o = FMT_R;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate decoder with a two-entry head/skid FIFO on valid/ready.
// IMM_CSR_ZIMM_EN (handled in imm_extract) enables the CSR zimm format.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  occ_e            occ_q, occ_d;
  entry_t          head_q, head_d;
  entry_t          skid_q, skid_d;
  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;
  logic            push;
  logic            pop;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst_i   (in_inst),
    .imm_o    (dec_imm),
    .fmt_o    (dec_fmt),
    .illegal_o(dec_illegal)
  );

  // Handshake depends only on the occupancy register, never on out_ready.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.tag     = in_tag;
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = new_entry;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            skid_d = new_entry;
            occ_d  = OCC_FULL;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;
  assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus; a queue model checks every cycle.
module tb_imm_decode_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;
  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt32, out_fmt64;
  logic        out_ill32, out_ill64;
  logic [31:0] out_tag32, out_tag64;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode from the field definitions: gather the raw field value,
  // then sign-extend arithmetically from its declared width.
  function automatic void ref_dec(input logic [31:0] inst, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint unsigned x, raw;
    int w;
    x = 64'(inst);
    raw = 0; w = 0; fmt = FMT_ILL; ill = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; raw = x & 64'hFFFF_F000; w = 32; end
      OPC_JAL: begin
        fmt = FMT_J; w = 21;
        raw = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12)
            | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt = FMT_I; raw = x >> 20; w = 12;
      end
      OPC_BRANCH: begin
        fmt = FMT_B; w = 13;
        raw = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
            | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
      end
      OPC_STORE: begin fmt = FMT_S; raw = ((x >> 25) << 5) | ((x >> 7) & 31); w = 12; end
      OPC_OP: fmt = FMT_R;
      default: ill = 1'b1;
    endcase
`ifdef IMM_CSR_ZIMM_EN
    if (inst[6:0] == OPC_SYSTEM && inst[14]) begin
      fmt = FMT_Z; raw = (x >> 15) & 31; w = 0;
    end
`endif
    if (w != 0 && raw >= (64'd1 << (w - 1))) raw = raw - (64'd1 << w);
    imm = raw;
  endfunction

  // Scoreboard: queue of accepted words, checked against both instances each cycle.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } ent_t;
  ent_t        q[$];
  ent_t        e_new;
  logic [63:0] m_imm;
  logic [2:0]  m_fmt;
  logic        m_ill;
  bit          m_acc, m_rel;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else if (mon_en) begin
      chk("mon_out_valid32", 64'(out_valid32), 64'(q.size() != 0));
      chk("mon_out_valid64", 64'(out_valid64), 64'(q.size() != 0));
      chk("mon_in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("mon_in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() != 0) begin
        ref_dec(q[0].inst, m_imm, m_fmt, m_ill);
        chk("mon_imm32", 64'(out_imm32), 64'(m_imm[31:0]));
        chk("mon_imm64", out_imm64, m_imm);
        chk("mon_fmt32", 64'(out_fmt32), 64'(m_fmt));
        chk("mon_fmt64", 64'(out_fmt64), 64'(m_fmt));
        chk("mon_ill", 64'(out_ill32), 64'(m_ill));
        chk("mon_tag", 64'(out_tag64), 64'(q[0].tag));
      end
      m_acc = in_valid && (q.size() < 2);
      m_rel = out_ready && (q.size() != 0);
      if (flush) begin
        q.delete();
      end else begin
        if (m_rel) void'(q.pop_front());
        if (m_acc) begin
          e_new.inst = in_inst;
          e_new.tag  = in_tag;
          q.push_back(e_new);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;
  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] imm32, input logic [63:0] imm64,
                          input logic [2:0] fmt, input logic ill, input logic [31:0] tag);
    chk({name, "_valid"}, 64'(out_valid32), 64'd1);
    chk({name, "_imm32"}, 64'(out_imm32), 64'(imm32));
    chk({name, "_imm64"}, out_imm64, imm64);
    chk({name, "_fmt"}, 64'(out_fmt32), 64'(fmt));
    chk({name, "_ill"}, 64'(out_ill64), 64'(ill));
    chk({name, "_tag"}, 64'(out_tag32), 64'(tag));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 64'(out_valid32 | out_valid64), 64'd0);
    chk({name, "_ready"}, 64'(in_ready32 & in_ready64), 64'd1);
    chk({name, "_imm"}, out_imm64 | 64'(out_imm32), 64'd0);
    chk({name, "_fmt"}, 64'(out_fmt32 | out_fmt64), 64'd0);
    chk({name, "_ill_tag"}, 64'(out_ill32 | out_ill64) | 64'(out_tag32 | out_tag64), 64'd0);
  endtask

  logic [6:0]  ops[11];
  logic [31:0] r;
  logic [6:0]  op;

  initial begin
    tbl[0] = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0};
    tbl[1] = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, FMT_U, 1'b0};
    tbl[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_B, 1'b0};
    tbl[3] = '{32'h0020A423, 32'h00000008, 64'h0000000000000008, FMT_S, 1'b0};
    tbl[4] = '{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J, 1'b0};
    tbl[5] = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U, 1'b0};
    tbl[6] = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, FMT_ILL, 1'b1};
`ifdef IMM_CSR_ZIMM_EN
    // rs1 field (inst[19:15]) of 0x30055073 is 5'b01010.
    tbl[7] = '{32'h30055073, 32'h0000000A, 64'h000000000000000A, FMT_Z, 1'b0};
`else
    tbl[7] = '{32'h30055073, 32'h00000300, 64'h0000000000000300, FMT_I, 1'b0};
`endif
    tbl[8] = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, FMT_R, 1'b0};
    tbl[9] = '{32'hFFC08067, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_I, 1'b0};
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk_zero("reset_state");

    // Table stream, one word per cycle, result one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step();
      if (i < 10) begin
        in_valid = 1'b1; in_inst = tbl[i].inst; in_tag = 32'h1000 + 32'(i * 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0)
        chk_head($sformatf("tbl%0d", i - 1), tbl[i-1].imm32, tbl[i-1].imm64,
                 tbl[i-1].fmt, tbl[i-1].ill, 32'h1000 + 32'((i - 1) * 4));
    end

    // Backpressure: A and B fill the FIFO, C waits, then all three drain back to back.
    step(); out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    step(); in_valid = 1'b1; in_inst = tbl[0].inst; in_tag = 32'hA;
    @(negedge clk); chk("bp_ready_a", 64'(in_ready32), 64'd1);
    step(); in_inst = tbl[3].inst; in_tag = 32'hB;
    @(negedge clk); chk("bp_ready_b", 64'(in_ready32), 64'd1);
    step(); in_inst = tbl[1].inst; in_tag = 32'hC;
    @(negedge clk);
    chk("bp_ready_c", 64'(in_ready32), 64'd0);
    chk_head("bp_hold", tbl[0].imm32, tbl[0].imm64, FMT_I, 1'b0, 32'hA);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk_head("bp_out_a", tbl[0].imm32, tbl[0].imm64, FMT_I, 1'b0, 32'hA);
    chk("bp_ready_reg", 64'(in_ready64), 64'd0);
    step();
    @(negedge clk);
    chk_head("bp_out_b", tbl[3].imm32, tbl[3].imm64, FMT_S, 1'b0, 32'hB);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk_head("bp_out_c", tbl[1].imm32, tbl[1].imm64, FMT_U, 1'b0, 32'hC);
    step();
    @(negedge clk); chk("bp_empty", 64'(out_valid32), 64'd0);

    // Flush with both entries full, then with one entry and an acceptable offer.
    out_ready = 1'b0;
    step(); in_valid = 1'b1; in_inst = tbl[2].inst; in_tag = 32'h11;
    step(); in_inst = tbl[4].inst; in_tag = 32'h12;
    step(); in_inst = tbl[5].inst; in_tag = 32'h13; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_valid", 64'(out_valid32 | out_valid64), 64'd0);
    chk("flush2_ready", 64'(in_ready32 & in_ready64), 64'd1);
    step(); out_ready = 1'b1;
    @(negedge clk); chk("flush2_no_word", 64'(out_valid32 | out_valid64), 64'd0);
    out_ready = 1'b0;
    step(); in_valid = 1'b1; in_inst = tbl[2].inst; in_tag = 32'h21;
    step(); in_inst = tbl[9].inst; in_tag = 32'h22; flush = 1'b1;
    @(negedge clk); chk("flush1_offer_ready", 64'(in_ready32), 64'd1);
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_valid", 64'(out_valid32 | out_valid64), 64'd0);
    chk("flush1_ready", 64'(in_ready32 & in_ready64), 64'd1);

    // Same again with reset instead of flush: every output returns to zero.
    step(); in_valid = 1'b1; in_inst = tbl[0].inst; in_tag = 32'h31;
    step(); in_inst = tbl[4].inst; in_tag = 32'h32;
    step(); in_inst = tbl[5].inst; in_tag = 32'h33; reset = 1'b1;
    step(); reset = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk_zero("midreset");
    step(); out_ready = 1'b1;
    @(negedge clk); chk("midreset_no_word", 64'(out_valid32 | out_valid64), 64'd0);

    // Randomized traffic, checked by the scoreboard.
    for (int n = 0; n < 600; n++) begin
      step();
      r = $urandom;
      op = (r[3:0] < 4'd11) ? ops[r[3:0]] : r[13:7];
      r = $urandom;
      in_inst = {r[31:7], op};
      in_tag = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 149) == 0);
    end
    step(); in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("drain_empty", 64'(out_valid32 | out_valid64), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
